// File: rtl/qspi_line_fetch.sv
// qspi_line_fetch: wakes a QSPI flash, then serves cache line fills with fast-read-quad-output (0x6B).
module qspi_line_fetch #(
  parameter int LINE_WORDS   = 4,
  parameter int DUMMY_CYCLES = 8,
  parameter int WAKE_GAP     = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [23:0]             req_addr,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                    csb,
  output logic [3:0]              io_out,
  output logic [3:0]              io_oe,
  input  logic [3:0]              io_in
);
  localparam logic [23:0] ALIGN    = ~24'(4*LINE_WORDS-1);
  localparam logic [7:0]  WAKE_CMD = 8'hAB;
  localparam logic [7:0]  READ_CMD = 8'h6B;
  typedef enum logic [2:0] {WAKE, WGAP, IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, nib;
  logic [23:0] addr_q;
  logic [32*LINE_WORDS-1:0] fill_q;
  logic last, accept, drive_n, bit_n;
  assign last      = cnt == 16'd0;
  assign req_ready = state == IDLE && (!line_valid || line_ready);
  assign accept    = req_valid && req_ready;
  // nibble slot: high nibble of each byte arrives first, bytes little-endian
  assign nib       = (16'(8*LINE_WORDS-1) - cnt) ^ 16'd1;
  always_comb begin
    state_n = state;
    cnt_n   = last ? cnt : cnt - 16'd1;
    case (state)
      WAKE:    if (last) begin state_n = WGAP; cnt_n = 16'(WAKE_GAP-1); end
      WGAP:    if (last) state_n = IDLE;
      IDLE:    if (accept) begin state_n = CMD; cnt_n = 16'd7; end
      CMD:     if (last) begin state_n = ADDR; cnt_n = 16'd23; end
      ADDR:    if (last) begin state_n = DUMMY; cnt_n = 16'(DUMMY_CYCLES-1); end
      DUMMY:   if (last) begin state_n = DATA; cnt_n = 16'(8*LINE_WORDS-1); end
      DATA:    if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
    drive_n = state_n inside {WAKE, CMD, ADDR};
    bit_n   = state_n == WAKE ? WAKE_CMD[cnt_n[2:0]] :
              state_n == CMD  ? READ_CMD[cnt_n[2:0]] :
              state_n == ADDR ? addr_q[cnt_n[4:0]] : 1'b0;
  end
  // reset parks in WAKE one count early so the first edge after release starts the 8-bit wake shift
  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) begin
      state      <= WAKE;
      cnt        <= 16'd8;
      addr_q     <= '0;
      fill_q     <= '0;
      line_data  <= '0;
      line_valid <= 1'b0;
      csb        <= 1'b1;
      io_out     <= 4'b0000;
      io_oe      <= 4'b0000;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      csb    <= !(state_n inside {WAKE, CMD, ADDR, DUMMY, DATA});
      io_oe  <= {3'b000, drive_n};
      io_out <= {3'b000, bit_n};
      if (accept) addr_q <= req_addr & ALIGN;
      if (state == DATA) fill_q[4*nib +: 4] <= io_in;
      if (state == DONE) begin
        line_data  <= fill_q;
        line_valid <= 1'b1;
      end else if (line_ready) line_valid <= 1'b0;
    end
endmodule

// File: doc/qspi_line_fetch.md
QSPI_LINE_FETCH -- requirements
Module: qspi_line_fetch

Interface
REQ-001 Parameters SHALL be:
- LINE_WORDS, 4: 32-bit words per cache line fill.
- DUMMY_CYCLES, 8: dummy clocks between address and data.
- WAKE_GAP, 4: csb-high clocks after the 0xAB wake command.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- aclk, in, 1: single clock; also the flash SPI clock.
- aresetn, in, 1: reset, asynchronous, active-high despite the name.
- req_valid, in, 1: line fill request from the cache.
- req_ready, out, 1: request accepted when high together with req_valid.
- req_addr, in, 24: flash byte address.
- line_valid, out, 1: filled line available.
- line_ready, in, 1: cache consumes the line.
- line_data, out, 32*LINE_WORDS: filled line.
- csb, out, 1: flash chip select, active low.
- io_out, out, 4: flash IO drive values.
- io_oe, out, 4: per-bit output enable; the wrapper builds the inout io[3:0].
- io_in, in, 4: sampled flash IO.

Function
REQ-003 FSM states SHALL be WAKE, WGAP, IDLE, CMD, ADDR, DUMMY, DATA, DONE, with one shared down-counter.
REQ-004 Startup sequence:
- The first aclk edge after reset release SHALL enter WAKE.
- WAKE: csb=0, shift 0xAB MSB-first on io0 for 8 cycles.
- WGAP: csb=1 for WAKE_GAP cycles, then IDLE.
REQ-005 req_ready SHALL equal (state==IDLE) && (!line_valid || line_ready).
REQ-006 On acceptance the block SHALL latch req_addr with the low log2(4*LINE_WORDS) bits cleared (line-aligned).
REQ-007 After acceptance the block SHALL enter CMD on the next edge; csb=0 and command 0x6B is shifted MSB-first on io0 for 8 cycles.
REQ-008 ADDR SHALL shift the aligned 24-bit address MSB-first on io0 for 24 cycles.
REQ-009 Output enables:
- io_oe=4'b0001 in WAKE, CMD and ADDR.
- io_oe=4'b0000 in every other state.
- io_out SHALL be 0 whenever not driven.
REQ-010 io_out and csb SHALL be registered on the rising edge of aclk; io_in SHALL be sampled on the rising edge of aclk.
REQ-011 DUMMY SHALL last DUMMY_CYCLES cycles with csb=0.
REQ-012 DATA SHALL last 8*LINE_WORDS cycles, sampling one nibble per cycle:
- High nibble first within each byte.
- Byte k of the line goes to line_data[8k+7:8k] (little-endian; byte 0 = lowest address).
REQ-013 DONE SHALL last 1 cycle:
- csb=1.
- line_data updated and line_valid set.
- Then IDLE.
REQ-014 csb-low time per fill SHALL be 32+DUMMY_CYCLES+8*LINE_WORDS cycles (72 at defaults); line_valid rises 73 cycles after the acceptance edge.
REQ-015 line_valid SHALL stay high, with line_data stable, until an edge where line_ready=1.
REQ-016 A new request accepted in the same cycle line_ready=1 SHALL be legal; line_valid clears and the new fill starts.
REQ-017 req_valid while not in IDLE SHALL be ignored; no request queueing.
REQ-018 line_ready while line_valid=0 SHALL have no effect.

Reset
REQ-019 While aresetn=1, outputs SHALL be held asynchronously at: csb=1, io_oe=0, io_out=0, req_ready=0, line_valid=0, line_data=0.
REQ-020 Reset asserted mid-fill SHALL abort the transfer immediately (csb high, no line delivered) and rerun WAKE/WGAP after release.

Verification
Flash model preloaded with byte[i] = i & 0xFF.
REQ-021 Reset release -> csb low exactly 8 cycles carrying 0xAB on io0, then high 4 cycles; req_ready first high on the 13th edge after release.
REQ-022 Request addr 0x000010 -> the following, with line_valid 73 cycles after acceptance:
- io0 carries 0x6B, then 0x000010.
- line_data = {0x1F1E1D1C, 0x1B1A1918, 0x17161514, 0x13121110}.
REQ-023 Request addr 0x00002B -> aligned to 0x000020; word0 = 0x23222120.
REQ-024 line_ready held 0 for 20 cycles after line_valid -> line_valid and line_data stable throughout and req_ready=0; raising line_ready with req_valid=1 (addr 0x40) -> same-edge accept, second fill yields word0 = 0x43424140.
REQ-025 aresetn pulsed high at cycle 40 of a fill -> csb=1 within the same cycle, line_valid never asserts, wake sequence repeats, next request completes correctly.
